// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, reset/halt constants and the fetch entry type
// for the instruction fetch front end.
package ifetch_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned BUF_DEPTH = 2;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Word-index PC increment; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory address/data and decode valid/ready bundle.
// master = fetch unit, slave = memory + decode side.
interface instr_fetch_if import ifetch_pkg::*; ();

  logic [ADDR_W-1:0]  pc_o;
  logic [INSTR_W-1:0] instr_i;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  instr_pc_o;
  logic               instr_valid_o;
  logic               instr_ready_i;

  modport master (
    output pc_o,
    output instr_o,
    output instr_pc_o,
    output instr_valid_o,
    input  instr_i,
    input  instr_ready_i
  );

  modport slave (
    input  pc_o,
    input  instr_o,
    input  instr_pc_o,
    input  instr_valid_o,
    output instr_i,
    output instr_ready_i
  );

endinterface

// File: rtl/ifetch_skid_buf.sv
// ifetch_skid_buf: 2-entry FIFO of fetch entries holding words that decode
// has not yet accepted. Flush wins over push and pop.
module ifetch_skid_buf import ifetch_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_push_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_occ
);

  fetch_entry_t r_mem [BUF_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;

  // Entry storage; contents only matter while counted in r_occ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Head entry and occupancy to the fetch control.
  always_comb begin
    o_head = r_mem[r_rd_ptr];
    o_occ  = r_occ;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, one-deep in-flight tracking for the 1-cycle
// synchronous instruction memory, issue credit, bypass mux and skid buffer
// toward decode.
// Optional feature macro: IFETCH_HALT_EN (stop fetch on a HALT_WORD handshake).
module instr_fetch import ifetch_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = ifetch_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_if.master       bus,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  output logic                halted_o
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  fetch_entry_t      w_head;
  fetch_entry_t      w_bypass;
  fetch_entry_t      w_out;
  logic [1:0]        w_occ;
  logic              w_buf_empty;
  logic              w_valid;
  logic              w_xfer;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic              w_issue;
  logic [2:0]        w_used;
  logic              w_halt_hit;
  logic              w_halted;

  assign bus.pc_o = r_pc;

  // Youngest word from memory, and selection between buffer head and bypass.
  always_comb begin
    w_bypass.instr = bus.instr_i;
    w_bypass.pc    = r_inflight_pc;
    w_buf_empty    = (w_occ == 2'd0);
    w_valid        = !w_buf_empty || r_inflight;
    w_out          = w_buf_empty ? w_bypass : w_head;
  end

  // Handshake, buffer control and issue credit. Credit counts words that will
  // still be held after this cycle, so the buffer can never overflow.
  always_comb begin
    w_xfer  = w_valid && bus.instr_ready_i;
    w_pop   = w_xfer && !w_buf_empty;
    w_push  = r_inflight && !(w_xfer && w_buf_empty);
    w_flush = redirect_i || w_halt_hit;
    w_used  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};
    w_issue = (w_used < 3'(BUF_DEPTH)) && !w_halted && !w_flush;
  end

  // Decode-facing outputs, zeroed while nothing is valid.
  always_comb begin
    bus.instr_valid_o = w_valid;
    bus.instr_o       = w_valid ? w_out.instr : '0;
    bus.instr_pc_o    = w_valid ? w_out.pc    : '0;
  end

  // PC and in-flight tracking; redirect outranks issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_i) begin
      r_pc       <= redirect_pc_i;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= pc_inc(r_pc);
      end
    end
  end

`ifdef IFETCH_HALT_EN
  logic r_halted;

  assign w_halt_hit = w_xfer && (w_out.instr == HALT_WORD);
  assign w_halted   = r_halted;
  assign halted_o   = r_halted;

  // Halt latches on an accepted halt word; a redirect restarts fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (redirect_i) begin
      r_halted <= 1'b0;
    end else if (w_halt_hit) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign w_halt_hit = 1'b0;
  assign w_halted   = 1'b0;
  assign halted_o   = 1'b0;
`endif

  ifetch_skid_buf u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_push_data (w_bypass),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for the instruction fetch front end.
// Memory model: word(a) = a ^ 16'h5A00, except word(9) = 16'h0000.
module tb_instr_fetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        halted_o;

  int checks = 0;
  int errors = 0;

  instr_fetch_if u_if ();

  instr_fetch u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (u_if),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'd9) return 16'h0000;
    return a ^ 16'h5A00;
  endfunction

  // Synchronous memory with one clock of latency.
  always @(posedge clk) u_if.instr_i <= mem_word(u_if.pc_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] ipc,
                           input logic [15:0] pco);
    check({tag, "_valid"}, {31'd0, u_if.instr_valid_o}, {31'd0, v});
    check({tag, "_pc"},    {16'd0, u_if.instr_pc_o}, {16'd0, v ? ipc : 16'h0000});
    check({tag, "_instr"}, {16'd0, u_if.instr_o},    {16'd0, v ? mem_word(ipc) : 16'h0000});
    check({tag, "_pc_o"},  {16'd0, u_if.pc_o},       {16'd0, pco});
  endtask

  task automatic check_reset(input string tag);
    check_out(tag, 1'b0, 16'h0000, RESET_PC);
    check({tag, "_halted"}, {31'd0, halted_o}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst                 = 1'b1;
    u_if.instr_ready_i  = 1'b0;
    redirect_i          = 1'b0;
    redirect_pc_i       = 16'h0000;
    repeat (2) @(posedge clk);
    #2;
    check_reset("in_reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        v;
    logic [15:0] ipc;
    logic [15:0] pco;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic rd, input logic [15:0] rp,
                              input logic v, input logic [15:0] ip, input logic [15:0] pc);
    vec_t t;
    t.ready = r; t.redir = rd; t.rpc = rp; t.v = v; t.ipc = ip; t.pco = pc;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    // streaming, 5-cycle stall at word 3, redirects incl. same-cycle handshake and wrap
    vecs[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 0, 16'h0000, 1, 16'h0000, 16'h0001);
    vecs[2]  = mk(1, 0, 16'h0000, 1, 16'h0001, 16'h0002);
    vecs[3]  = mk(1, 0, 16'h0000, 1, 16'h0002, 16'h0003);
    vecs[4]  = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h0004);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h0005);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h0005);
    vecs[7]  = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h0005);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h0003, 16'h0005);
    vecs[9]  = mk(1, 0, 16'h0000, 1, 16'h0003, 16'h0005);
    vecs[10] = mk(1, 0, 16'h0000, 1, 16'h0004, 16'h0006);
    vecs[11] = mk(1, 0, 16'h0000, 1, 16'h0005, 16'h0007);
    vecs[12] = mk(0, 1, 16'h0005, 1, 16'h0006, 16'h0008);
    vecs[13] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0005);
    vecs[14] = mk(1, 0, 16'h0000, 1, 16'h0005, 16'h0006);
    vecs[15] = mk(1, 1, 16'h0020, 1, 16'h0006, 16'h0007);
    vecs[16] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0020);
    vecs[17] = mk(1, 0, 16'h0000, 1, 16'h0020, 16'h0021);
    vecs[18] = mk(1, 1, 16'hFFFE, 1, 16'h0021, 16'h0022);
    vecs[19] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'hFFFE);
    vecs[20] = mk(1, 0, 16'h0000, 1, 16'hFFFE, 16'hFFFF);
    vecs[21] = mk(1, 0, 16'h0000, 1, 16'hFFFF, 16'h0000);
    vecs[22] = mk(1, 0, 16'h0000, 1, 16'h0000, 16'h0001);

    apply_reset();
    for (int i = 0; i < NVEC; i++) begin
      u_if.instr_ready_i = vecs[i].ready;
      redirect_i         = vecs[i].redir;
      redirect_pc_i      = vecs[i].rpc;
      #1;
      check_out($sformatf("row%0d", i), vecs[i].v, vecs[i].ipc, vecs[i].pco);
      step();
    end
    redirect_i = 1'b0;

    // halt word at address 9
    apply_reset();
    u_if.instr_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) step();
    #1;
    check_out("halt_word", 1'b1, 16'd9, 16'd10);
    check("halt_word_halted", {31'd0, halted_o}, 32'd0);
    step();
    #1;
`ifdef IFETCH_HALT_EN
    check_out("halt_c11", 1'b0, 16'd0, 16'd10);
    check("halt_c11_halted", {31'd0, halted_o}, 32'd1);
    step();
    #1;
    check_out("halt_c12", 1'b0, 16'd0, 16'd10);
    check("halt_c12_halted", {31'd0, halted_o}, 32'd1);
`else
    check_out("nohalt_c11", 1'b1, 16'd10, 16'd11);
    check("nohalt_c11_halted", {31'd0, halted_o}, 32'd0);
    step();
    #1;
    check_out("nohalt_c12", 1'b1, 16'd11, 16'd12);
    check("nohalt_c12_halted", {31'd0, halted_o}, 32'd0);
`endif
    redirect_i    = 1'b1;
    redirect_pc_i = 16'h0000;
    step();
    redirect_i = 1'b0;
    #1;
    check_out("restart_c13", 1'b0, 16'd0, 16'd0);
    check("restart_c13_halted", {31'd0, halted_o}, 32'd0);
    step();
    #1;
    check_out("restart_c14", 1'b1, 16'd0, 16'd1);

    // reset pulsed while the buffer holds two words
    apply_reset();
    u_if.instr_ready_i = 1'b0;
    #1;
    check_out("stall_c0", 1'b0, 16'd0, 16'd0);
    step();
    #1;
    check_out("stall_c1", 1'b1, 16'd0, 16'd1);
    step();
    #1;
    check_out("stall_c2", 1'b1, 16'd0, 16'd2);
    step();
    #1;
    check_out("stall_c3", 1'b1, 16'd0, 16'd2);
    rst = 1'b1;
    #1;
    check_reset("rst_mid_stall");
    step();
    rst = 1'b0;
    u_if.instr_ready_i = 1'b1;
    #1;
    check_out("post_rst_c0", 1'b0, 16'd0, RESET_PC);
    step();
    #1;
    check_out("post_rst_c1", 1'b1, 16'd0, 16'd1);
    step();
    #1;
    check_out("post_rst_c2", 1'b1, 16'd1, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
